// File: rtl/picomips_io_if.sv
// Core-side handshake between the board I/O sequencer and picoMIPS:
// operand request (branch_status), frozen operand (SW) and result (outport).
interface picomips_io_if #(
    parameter int n = 8
);
    logic         branch_status;
    logic [n-1:0] SW;
    logic [n-1:0] outport;

    modport master (output branch_status, output SW, input outport);
    modport slave  (input branch_status, input SW, output outport);
endinterface

// File: rtl/picomips_io_ctrl.sv
// Board-side I/O sequencer for picoMIPS: sync + debounce key/switches, press/compute/ack handshake.
// Optional watchdog on the ARMED state is enabled by defining PICO_IO_TIMEOUT_EN.
module picomips_io_ctrl #(
    parameter int n              = 8,
    parameter int DB_CYCLES      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_n,
    input  logic [n-1:0]         SW_raw,
    picomips_io_if.master        core,
    output logic [n-1:0]         LED,
    output logic                 busy,
    output logic [7:0]           result_count,
    output logic                 timeout
);
    localparam int CNT_W = $clog2(DB_CYCLES);

    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

    logic             key_s1_q, key_s_q;
    logic [n-1:0]     sw_s1_q, sw_s_q;
    logic             key_db_q, key_db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic             branch_q, branch_d;
    logic [n-1:0]     sw_q, sw_d;
    logic [n-1:0]     led_q, led_d;
    logic             busy_q, busy_d;
    logic [7:0]       rc_q, rc_d;
    logic             press, rel, result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_s1_q <= 1'b1;
            key_s_q  <= 1'b1;
            sw_s1_q  <= '0;
            sw_s_q   <= '0;
        end else begin
            key_s1_q <= key_n;
            key_s_q  <= key_s1_q;
            sw_s1_q  <= SW_raw;
            sw_s_q   <= sw_s1_q;
        end
    end

    // Accept a new key level only after DB_CYCLES consecutive differing samples.
    always_comb begin
        cnt_d    = '0;
        key_db_d = key_db_q;
        if (key_s_q != key_db_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1))
                key_db_d = key_s_q;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    // Edges are taken from the debounced level as it updates, so the FSM reacts on the same edge.
    assign press  = key_db_q & ~key_db_d;
    assign rel    = ~key_db_q & key_db_d;
    assign result = |core.outport;

`ifdef PICO_IO_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        to_q, to_d;
    logic        wd_expire;
    assign wd_expire = (wd_q == 16'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d  = state_q;
        branch_d = branch_q;
        sw_d     = sw_q;
        rc_d     = rc_q;
        led_d    = result ? core.outport : led_q;
`ifdef PICO_IO_TIMEOUT_EN
        wd_d     = wd_q;
        to_d     = to_q;
`endif
        case (state_q)
            IDLE: begin
                sw_d     = sw_s_q;
                branch_d = 1'b0;
                if (press) begin
                    branch_d = 1'b1;
                    state_d  = ARMED;
`ifdef PICO_IO_TIMEOUT_EN
                    wd_d     = '0;
                    to_d     = 1'b0;
`endif
                end
            end
            ARMED: begin
`ifdef PICO_IO_TIMEOUT_EN
                wd_d = wd_q + 16'd1;
`endif
                // A result always wins over release or watchdog expiry in the same cycle.
                if (result) begin
                    branch_d = 1'b0;
                    rc_d     = rc_q + 8'd1;
                    state_d  = rel ? IDLE : DONE;
                end else if (rel) begin
                    branch_d = 1'b0;
                    state_d  = IDLE;
                end
`ifdef PICO_IO_TIMEOUT_EN
                else if (wd_expire) begin
                    branch_d = 1'b0;
                    to_d     = 1'b1;
                    state_d  = DONE;
                end
`endif
            end
            DONE: begin
                branch_d = 1'b0;
                if (rel) state_d = IDLE;
            end
            default: begin
                branch_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_db_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= IDLE;
            branch_q <= 1'b0;
            sw_q     <= '0;
            led_q    <= '0;
            busy_q   <= 1'b0;
            rc_q     <= '0;
        end else begin
            key_db_q <= key_db_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            branch_q <= branch_d;
            sw_q     <= sw_d;
            led_q    <= led_d;
            busy_q   <= busy_d;
            rc_q     <= rc_d;
        end
    end

`ifdef PICO_IO_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end
    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    assign core.branch_status = branch_q;
    assign core.SW            = sw_q;
    assign LED                = led_q;
    assign busy               = busy_q;
    assign result_count       = rc_q;
endmodule

// File: tb/tb_picomips_io_ctrl.sv
// Self-checking bench for picomips_io_ctrl: directed scenarios plus randomized key/switch/outport
// traffic compared against a window-based behavioural model.
module tb_picomips_io_ctrl;
    localparam int N  = 8;
    localparam int DB = 6;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         key_n = 1'b1;
    logic [N-1:0] SW_raw = '0;
    logic [N-1:0] LED;
    logic [7:0]   result_count;
    logic         busy, timeout;
    int           total = 0;
    int           bad = 0;

    picomips_io_if #(.n(N)) io ();

    picomips_io_ctrl #(.n(N), .DB_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .key_n(key_n), .SW_raw(SW_raw), .core(io),
        .LED(LED), .busy(busy), .result_count(result_count), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Behavioural model: key is debounced by "last DB synchronised samples all differ".
    bit           m_k1, m_ks, m_db;
    logic [N-1:0] m_sw1, m_sws, m_sw, m_led;
    bit           hist[$];
    int           m_phase;          // 0 waiting, 1 request pending, 2 answered
    bit           m_bs, m_to;
    logic [7:0]   m_rc;
    int           m_wd;

    task automatic model_reset();
        m_k1 = 1; m_ks = 1; m_db = 1; m_sw1 = '0; m_sws = '0; m_sw = '0; m_led = '0;
        hist.delete();
        for (int i = 0; i < DB; i++) hist.push_back(1'b1);
        m_phase = 0; m_bs = 0; m_to = 0; m_rc = '0; m_wd = 0;
    endtask

    task automatic model_step();
        bit flip = 1;
        bit pr, rl;
        hist.push_back(m_ks);
        void'(hist.pop_front());
        foreach (hist[i]) if (hist[i] == m_db) flip = 0;
        pr = flip && m_db;
        rl = flip && !m_db;
        if (flip) m_db = !m_db;
        if (io.outport != 0) m_led = io.outport;
        if (m_phase == 0) begin
            m_sw = m_sws;
            if (pr) begin m_bs = 1; m_phase = 1; m_wd = 0; m_to = 0; end
        end else if (m_phase == 1) begin
            if (io.outport != 0) begin
                m_bs = 0; m_rc = m_rc + 1; m_phase = rl ? 0 : 2;
            end else if (rl) begin
                m_bs = 0; m_phase = 0;
            end
`ifdef PICO_IO_TIMEOUT_EN
            else if (m_wd == TO - 1) begin
                m_bs = 0; m_to = 1; m_phase = 2;
            end
            m_wd++;
`endif
        end else begin
            if (rl) m_phase = 0;
        end
        m_ks = m_k1; m_k1 = key_n; m_sws = m_sw1; m_sw1 = SW_raw;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Ticks until the selected output reaches val; n = ticks taken, or -1 when the bound expires.
    task automatic wait_for(input int sel, input logic val, output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if ((sel == 0 && io.branch_status == val) || (sel == 1 && busy == val) ||
                (sel == 2 && timeout == val)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        io.outport = '0; key_n = 1'b1; SW_raw = 8'h5A;
        reset = 1'b1;
        model_reset();
        #1;
        total++;
        if ({io.branch_status, io.SW, LED, busy, result_count, timeout} !== '0) begin
            bad++;
            $display("FAIL reset_state: got bs=%b sw=%h led=%h busy=%b rc=%0d to=%b, want all zero",
                     io.branch_status, io.SW, LED, busy, result_count, timeout);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_idle_follow();
        tick(); tick();
        total++;
        if (io.SW !== 8'h00) begin bad++; $display("FAIL sw_latency2: got %h want 00", io.SW); end
        tick();
        total++;
        if (io.SW !== 8'h5A || io.branch_status !== 1'b0 || LED !== 8'h00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_follow: got sw=%h bs=%b led=%h busy=%b want 5a 0 00 0",
                     io.SW, io.branch_status, LED, busy);
        end
    endtask

    task automatic test_glitch();
        for (int len = DB - 2; len <= DB - 1; len++) begin
            key_n = 1'b0;
            repeat (len) tick();
            key_n = 1'b1;
            for (int i = 0; i < DB + 4; i++) begin
                tick();
                total++;
                if (io.branch_status !== 1'b0 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL glitch_len%0d: got bs=%b busy=%b want 0 0", len, io.branch_status, busy);
                end
            end
        end
    endtask

    task automatic test_press_compute();
        int n;
        SW_raw = 8'h21;
        repeat (3) tick();
        key_n = 1'b0;
        wait_for(0, 1'b1, n);
        total++;
        if (n != 2 + DB || busy !== 1'b1) begin
            bad++; $display("FAIL press_latency: got %0d busy=%b want %0d 1", n, busy, 2 + DB);
        end
        SW_raw = 8'hFF;
        repeat (4) tick();
        total++;
        if (io.SW !== 8'h21) begin bad++; $display("FAIL sw_frozen: got %h want 21", io.SW); end
        io.outport = 8'h42;
        tick();
        io.outport = 8'h00;
        total++;
        if (LED !== 8'h42 || io.branch_status !== 1'b0 || result_count !== 8'd1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL result_ack: got led=%h bs=%b rc=%0d busy=%b want 42 0 1 1",
                     LED, io.branch_status, result_count, busy);
        end
        repeat (3) tick();
        total++;
        if (LED !== 8'h42 || busy !== 1'b1 || timeout !== 1'b0) begin
            bad++; $display("FAIL done_hold: got led=%h busy=%b to=%b want 42 1 0", LED, busy, timeout);
        end
        key_n = 1'b1;
        wait_for(1, 1'b0, n);
        total++;
        if (n != 2 + DB) begin bad++; $display("FAIL release_latency: got %0d want %0d", n, 2 + DB); end
        tick();
        total++;
        if (io.SW !== 8'hFF) begin bad++; $display("FAIL sw_resume: got %h want ff", io.SW); end
    endtask

    task automatic test_release_no_result();
        int n;
        do_reset();
        key_n = 1'b0;
        wait_for(0, 1'b1, n);
        repeat (5) tick();
        key_n = 1'b1;
        wait_for(0, 1'b0, n);
        total++;
        if (n != 2 + DB || LED !== 8'h00 || result_count !== 8'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL release_no_result: got n=%0d led=%h rc=%0d busy=%b want %0d 00 0 0",
                     n, LED, result_count, busy, 2 + DB);
        end
    endtask

    task automatic test_reset_while_armed();
        int n;
        SW_raw = 8'h33;
        repeat (3) tick();
        key_n = 1'b0;
        wait_for(0, 1'b1, n);
        #2 reset = 1'b1;
        model_reset();
        #1;
        total++;
        if (io.branch_status !== 1'b0 || io.SW !== 8'h00 || busy !== 1'b0) begin
            bad++; $display("FAIL async_reset: got bs=%b sw=%h busy=%b want 0 00 0", io.branch_status, io.SW, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        wait_for(0, 1'b1, n);
        total++;
        if (n != 2 + DB) begin bad++; $display("FAIL held_key_repress: got %0d want %0d", n, 2 + DB); end
        key_n = 1'b1;
        wait_for(1, 1'b0, n);
    endtask

`ifdef PICO_IO_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_reset();
        key_n = 1'b0;
        wait_for(0, 1'b1, n);
        wait_for(2, 1'b1, n);
        total++;
        if (n != TO || io.branch_status !== 1'b0 || result_count !== 8'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL watchdog: got n=%0d bs=%b rc=%0d busy=%b want %0d 0 0 1",
                     n, io.branch_status, result_count, busy, TO);
        end
        key_n = 1'b1;
        wait_for(1, 1'b0, n);
        key_n = 1'b0;
        wait_for(0, 1'b1, n);
        total++;
        if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_clear: got %b want 0", timeout); end
        key_n = 1'b1;
        wait_for(1, 1'b0, n);
    endtask
`endif

    task automatic test_random();
        int hold = 0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                key_n = 1'($urandom_range(0, 1));
                hold  = $urandom_range(1, 3 * DB + 4);
            end
            hold--;
            if ($urandom_range(0, 7) == 0) SW_raw = 8'($urandom);
            io.outport = ($urandom_range(0, 24) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            tick();
            total++;
            if ({io.branch_status, io.SW, LED, busy, result_count, timeout} !==
                {m_bs, m_sw, m_led, (m_phase != 0), m_rc, m_to}) begin
                bad++;
                $display("FAIL random_c%0d: got bs=%b sw=%h led=%h busy=%b rc=%0d to=%b want %b %h %h %b %0d %b",
                         c, io.branch_status, io.SW, LED, busy, result_count, timeout,
                         m_bs, m_sw, m_led, (m_phase != 0), m_rc, m_to);
            end
        end
        io.outport = '0;
    endtask

    initial begin
        test_reset();
        test_idle_follow();
        test_glitch();
        test_press_compute();
        test_release_no_result();
        test_reset_while_armed();
`ifdef PICO_IO_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
